// File: rtl/reg_stream_rx.sv
// Receive side of a registered valid/ready stream: a DEPTH-entry circular buffer
// with handshakes driven only from registers, plus a saturating count of refused offers.
module reg_stream_rx #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic [7:0]       r_drop;
    logic             r_armed;

    logic w_push;
    logic w_pop;
    logic w_drop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Handshake outputs come from registers only, so no input-to-ready path exists.
    assign in_ready  = r_armed && (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rp];
    assign count     = r_count;
    assign drop_cnt  = r_drop;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;
    assign w_drop = in_valid && r_armed && !in_ready;

    // Storage is deliberately not reset; it is unobservable while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_drop  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_drop <= sat_inc(r_drop);
            end
        end
    end

endmodule

// File: tb/tb_reg_stream_rx.sv
// Scoreboard bench for reg_stream_rx: accepted words are queued at the handshake
// and compared in order as the consumer takes them; status outputs checked at key points.
module tb_reg_stream_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic [7:0] drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pops = 0;
    logic [7:0] sb_q [$];

    reg_stream_rx #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are observed mid-cycle, where inputs and registered outputs are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_pops++;
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    logic [7:0] e;
                    e = sb_q.pop_front();
                    chk("out_data", out_data, e);
                end
            end
            if (in_valid && in_ready) sb_q.push_back(in_data);
        end
    end

    task automatic push_n(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        out_ready = 1'b1;
        while (out_valid && budget > 0) begin
            cyc();
            budget--;
        end
        out_ready = 1'b0;
        chk("drain_timeout", budget > 0, 1);
        chk("drain_empty", out_valid, 0);
    endtask

    initial begin
        logic [7:0] d0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_count", count, 0);
            chk("rst_drop", drop_cnt, 0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("prearm_in_ready", in_ready, 0);
        cyc();
        chk("arm_in_ready", in_ready, 1);
        chk("arm_drop", drop_cnt, 0);
        chk("arm_count", count, 0);

        // Fill, then refuse offers while full.
        push_n(8'h11, 1);
        push_n(8'h22, 1);
        push_n(8'h33, 1);
        push_n(8'h44, 1);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) cyc();
        in_valid = 1'b0;
        chk("drop3", drop_cnt, 3);
        chk("drop3_count", count, 4);
        drain();
        chk("drain1_pops", n_pops, 4);
        chk("drain1_count", count, 0);

        // Steady simultaneous push/pop at occupancy 2.
        push_n(8'hA0, 2);
        chk("pp_start_count", count, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA2 + 8'(i);
            cyc();
            chk("pp_count", count, 2);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        drain();
        chk("pp_pops", n_pops, 16);

        // Full with pop: pop happens, offer refused, next cycle it lands.
        push_n(8'hB0, 4);
        chk("fp_full", count, 4);
        d0 = drop_cnt;
        in_valid  = 1'b1;
        in_data   = 8'hB4;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("fp_count", count, 3);
        chk("fp_drop", drop_cnt, d0 + 8'd1);
        chk("fp_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("fp_refill", count, 4);
        chk("fp_drop_hold", drop_cnt, d0 + 8'd1);

        // Saturation of the refused-offer counter.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (300) cyc();
        chk("sat_255", drop_cnt, 8'hFF);
        repeat (5) cyc();
        in_valid = 1'b0;
        chk("sat_hold", drop_cnt, 8'hFF);

        // Asynchronous reset in the middle of a cycle at occupancy 3.
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("mid_count3", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_drop", drop_cnt, 0);
        sb_q.delete();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("rearm_in_ready", in_ready, 1);
        push_n(8'hA5, 1);
        chk("fresh_valid", out_valid, 1);
        chk("fresh_data", out_data, 8'hA5);
        drain();
        chk("sb_empty_end", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/reg_stream_rx.md
# reg_stream_rx

Receiving end of a registered valid/ready stream. Accepts words from a registered producer, buffers them in a small circular FIFO and presents them to a downstream consumer. Counts words offered while the buffer is full and therefore refused. Sits between a clocked producer stage and its consumer in the same clock domain.

## Interface

- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, buffer entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, occupancy width (derived, not overridable)

- clk  input  1  rising-edge clock, sole clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  producer offers in_data this cycle
- in_data  input  WIDTH  offered word
- in_ready  output  1  receiver will accept a word this cycle
- out_valid  output  1  head word available
- out_data  output  WIDTH  head word
- out_ready  input  1  consumer takes head word this cycle
- count  output  CW  current occupancy, 0..DEPTH
- drop_cnt  output  8  saturating count of refused offers

## Operation

- Storage: DEPTH×WIDTH array, write pointer wp and read pointer rp, each log2(DEPTH) bits, wrap naturally modulo DEPTH. Occupancy register count.
- Armed flag `armed`: cleared by reset, set on first rising clk after rst_n deasserts, then stays 1.
- in_ready = armed & (count != DEPTH), combinational from registers only (no path from in_valid or out_ready).
- push = in_valid & in_ready; writes in_data at wp, wp+1.
- out_valid = (count != 0); out_data = mem[rp], combinational read of head.
- pop = out_valid & out_ready; rp+1.
- count next = count + push − pop; push and pop in the same cycle leave count unchanged.
- Full with out_ready=1: in_ready is 0, so no push that cycle even though a slot frees; push possible the following cycle. No pass-through.
- Empty with in_valid=1: word is written; out_valid rises the next cycle. No bypass.
- drop: in_valid & armed & !in_ready increments drop_cnt, saturating at 255. Offers before armed are not counted.
- out_data when out_valid=0 is don't-care; the bench must not check it.
- Reset (asynchronous, any time including mid-transfer): wp, rp, count, drop_cnt, armed → 0 immediately. Buffer contents are not cleared and are unobservable, since out_valid=0. An in-flight word offered in the reset cycle is lost and not counted.

## Timing

- Reset values: in_ready=0, out_valid=0, count=0, drop_cnt=0; out_data undefined.
- First clk edge after release: armed=1; in_ready=1 from that cycle onward.
- Latency in_data → out_data: 1 cycle (accepted at edge N, visible with out_valid after edge N).
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- All state updates on rising clk; outputs change only on clk edges or on rst_n assertion.
- No combinational path from inputs to in_ready, out_valid or count.

## Test plan

- Reset/arm: hold rst_n=0 with in_valid=1 for 3 cycles, release → in_ready=0 until first edge, then 1. count=0, drop_cnt=0, out_valid=0 throughout.
- Fill and refuse (DEPTH=4): push 0x11,0x22,0x33,0x44 with out_ready=0 → count=4, in_ready=0. Offer 0x55 for 3 cycles → drop_cnt=3, 0x55 never appears. Drain yields 0x11,0x22,0x33,0x44 in order, then out_valid=0.
- Simultaneous push/pop: at count=2, drive in_valid=1 and out_ready=1 for 10 cycles with incrementing data → count stays 2, output order strictly matches input order. Pointers wrap at least twice without loss.
- Full + pop same cycle: at count=4, in_valid=1 and out_ready=1 → that cycle pops, no push, drop_cnt+1. Next cycle push succeeds, count back to 4.
- Saturation: keep full and offer for 300 cycles → drop_cnt=255 and holds.
- Reset mid-operation: at count=3, assert rst_n between clock edges → count, out_valid, in_ready go to 0 without a clk edge. After release and arm, a fresh push of 0xA5 is the first word out.
